// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-addressed memory responder.
// Holds the FSM state encoding, bus widths and the request error check.
package mem_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // A request is bad when it is not word aligned or its word index lies past the array.
   // The full upper address is compared so large addresses never alias onto low words.
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
      logic [ADDR_W-1:0] word_idx;
      word_idx = {2'b00, addr[ADDR_W-1:2]};
      return (addr[1:0] != 2'b00) || (word_idx >= depth);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage: synchronous write, registered read.
// Contents are deliberately not reset so data survives a responder reset.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = WORD_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed response latency.
// Handshake: a beat moves on a rising edge where valid and ready are both high.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output state_t            state_dbg
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              rd_ok;
   logic              accept;
   logic              fire;
   logic              cur_wr;
   logic              cur_err;
   logic [ADDR_W-1:0] cur_addr;
   logic [WORD_W-1:0] cur_wdata;
   logic [WORD_W-1:0] mem_rdata;

   assign accept = (state == IDLE) && req_ready && req_valid;

   // With zero latency the array is touched on the accept edge, so use the live request.
   assign cur_wr    = (state == IDLE) ? req_wr    : wr_q;
   assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign cur_err   = addr_err(cur_addr, DEPTH);

   assign fire = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0));

   mem_word_array #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_array (
      .clk   (clk),
      .en    (fire),
      .we    (cur_wr && !cur_err),
      .addr  (cur_addr[IDX_W+1:2]),
      .wdata (cur_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rd_ok     <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wr_q      <= req_wr;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  state     <= WAIT;
                  cnt       <= CNT_INIT;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rd_ok     <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         // Entering RESP overrides the WAIT transition taken on a zero-latency accept.
         if (fire) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rd_ok     <= !cur_wr && !cur_err;
         end
      end
   end

   assign rsp_rdata = rd_ok ? mem_rdata : '0;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance against a transaction-level model.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int DEPTH = 256;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [1:0]        req_valid, req_wr, rsp_ready;
   logic [1:0][31:0]  req_addr, req_wdata;
   logic [1:0]        req_ready, rsp_valid, rsp_err, busy;
   logic [1:0][31:0]  rsp_rdata;
   state_t            dbg0, dbg1;

   mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .busy(busy[0]), .state_dbg(dbg0)
   );

   mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .busy(busy[1]), .state_dbg(dbg1)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      end
   endtask

   // transaction-level model
   typedef struct {
      bit          ready;
      bit          active;
      bit          valid;
      bit          wr;
      bit          err;
      int          left;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } mdl_t;

   mdl_t        m [2];
   logic [31:0] mem_m [2][DEPTH];

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   task automatic mdl_reset(input int k);
      m[k].ready = 0; m[k].active = 0; m[k].valid = 0; m[k].wr = 0; m[k].err = 0;
      m[k].left = 0; m[k].addr = '0; m[k].wdata = '0; m[k].rdata = '0;
   endtask

   task automatic mdl_complete(input int k);
      logic [31:0] widx;
      bit e;
      widx = m[k].addr / 4;
      e = (m[k].addr % 4 != 0) || (widx >= DEPTH);
      if (!e && m[k].wr) mem_m[k][widx] = m[k].wdata;
      m[k].rdata  = (e || m[k].wr) ? 32'h0 : mem_m[k][widx];
      m[k].err    = e;
      m[k].valid  = 1;
      m[k].active = 0;
   endtask

   task automatic mdl_step(input int k);
      if (m[k].valid) begin
         if (rsp_ready[k]) begin
            m[k].valid = 0;
            m[k].ready = 1;
         end
      end else if (m[k].active) begin
         m[k].left--;
         if (m[k].left == 0) mdl_complete(k);
      end else if (m[k].ready) begin
         if (req_valid[k]) begin
            m[k].ready = 0;
            m[k].wr    = req_wr[k];
            m[k].addr  = req_addr[k];
            m[k].wdata = req_wdata[k];
            m[k].left  = lat_of(k);
            if (m[k].left == 0) mdl_complete(k);
            else m[k].active = 1;
         end
      end else begin
         m[k].ready = 1;
      end
   endtask

   initial begin
      mdl_reset(0);
      mdl_reset(1);
      forever begin
         @(posedge clk or negedge rst);
         for (int k = 0; k < 2; k++) begin
            if (rst !== 1'b1) mdl_reset(k);
            else mdl_step(k);
         end
      end
   end

   // scoreboard compare on every falling edge while out of reset
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("cmp_req_ready%0d", k), 32'(req_ready[k]), 32'(m[k].ready));
               chk($sformatf("cmp_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'(m[k].valid));
               chk($sformatf("cmp_busy%0d", k), 32'(busy[k]), 32'(m[k].active || m[k].valid));
               if (m[k].valid) begin
                  chk($sformatf("cmp_rdata%0d", k), rsp_rdata[k], m[k].rdata);
                  chk($sformatf("cmp_err%0d", k), 32'(rsp_err[k]), 32'(m[k].err));
               end
            end
         end
      end
   end

   // driver: called at a falling edge, returns at the falling edge after the response handshake
   task automatic do_req(input int k, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input logic [31:0] exp_hold,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int acc_cyc);
      int n;
      req_wr[k]    = wr;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_valid[k] = 1'b1;
      rsp_ready[k] = (hold == 0);
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("req_ready_timeout", 32'(req_ready[k]), 32'd1);
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
      req_valid[k] = 1'b0;
      lat = 1;
      while (rsp_valid[k] !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_rdata[k];
      err   = rsp_err[k];
      if (hold > 0) begin
         // a second request while the response is pending must be ignored
         req_valid[k] = 1'b1;
         req_wr[k]    = 1'b1;
         req_addr[k]  = 32'h0000_0020;
         req_wdata[k] = 32'hBAD0_BAD0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata[k], exp_hold);
            chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
         end
         req_valid[k] = 1'b0;
         rsp_ready[k] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, a1, a2, a3;
      logic [31:0] rd;
      logic        er;

      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_wr[k] = 1'b0; rsp_ready[k] = 1'b0;
         req_addr[k] = '0; req_wdata[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
         chk("rst_busy", 32'(busy[k]), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
      end
      chk("rst_state0", 32'(dbg0), 32'(IDLE));
      chk("rst_state1", 32'(dbg1), 32'(IDLE));
      rst = 1'b1;
      @(negedge clk);
      chk("first_edge_ready0", 32'(req_ready[0]), 32'd1);
      chk("first_edge_ready1", 32'(req_ready[1]), 32'd1);

      // LATENCY=2 store then load
      do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, '0, lat, rd, er, a1);
      chk("st10_latency", 32'(lat), 32'd3);
      chk("st10_err", 32'(er), 32'd0);
      chk("st10_rdata", rd, 32'd0);
      do_req(0, 1'b0, 32'h10, '0, 0, '0, lat, rd, er, a1);
      chk("ld10_latency", 32'(lat), 32'd3);
      chk("ld10_rdata", rd, 32'hDEAD_BEEF);

      // error cases
      do_req(0, 1'b0, 32'h12, '0, 0, '0, lat, rd, er, a1);
      chk("ld12_err", 32'(er), 32'd1);
      chk("ld12_rdata", rd, 32'd0);
      do_req(0, 1'b0, 32'h400, '0, 0, '0, lat, rd, er, a1);
      chk("ld400_err", 32'(er), 32'd1);
      chk("ld400_rdata", rd, 32'd0);
      do_req(0, 1'b1, 32'h410, 32'h1111_1111, 0, '0, lat, rd, er, a1);
      chk("st410_err", 32'(er), 32'd1);
      do_req(0, 1'b0, 32'h8000_0010, '0, 0, '0, lat, rd, er, a1);
      chk("ld_high_err", 32'(er), 32'd1);
      do_req(0, 1'b1, 32'h3FC, 32'hA5A5_0001, 0, '0, lat, rd, er, a1);
      chk("st3fc_err", 32'(er), 32'd0);
      do_req(0, 1'b0, 32'h3FC, '0, 0, '0, lat, rd, er, a1);
      chk("ld3fc_rdata", rd, 32'hA5A5_0001);
      do_req(0, 1'b0, 32'h10, '0, 0, '0, lat, rd, er, a1);
      chk("ld10_unchanged", rd, 32'hDEAD_BEEF);

      // response held for 5 cycles
      do_req(0, 1'b0, 32'h10, '0, 5, 32'hDEAD_BEEF, lat, rd, er, a1);
      chk("hold_first_rdata", rd, 32'hDEAD_BEEF);
      chk("hold_first_err", 32'(er), 32'd0);

      // LATENCY=0 back-to-back
      do_req(1, 1'b1, 32'h40, 32'h0BAD_CAFE, 0, '0, lat, rd, er, a1);
      chk("l0_st40_latency", 32'(lat), 32'd1);
      do_req(1, 1'b1, 32'h44, 32'h1357_2468, 0, '0, lat, rd, er, a1);
      do_req(1, 1'b0, 32'h40, '0, 0, '0, lat, rd, er, a1);
      chk("l0_ld40_latency", 32'(lat), 32'd1);
      chk("l0_ld40_rdata", rd, 32'h0BAD_CAFE);
      do_req(1, 1'b0, 32'h44, '0, 0, '0, lat, rd, er, a2);
      chk("l0_ld44_rdata", rd, 32'h1357_2468);
      chk("l0_spacing_a", 32'(a2 - a1), 32'd2);
      do_req(1, 1'b0, 32'h40, '0, 0, '0, lat, rd, er, a3);
      chk("l0_spacing_b", 32'(a3 - a2), 32'd2);

      // reset during WAIT aborts the store
      do_req(0, 1'b1, 32'h20, 32'hCAFE_F00D, 0, '0, lat, rd, er, a1);
      req_wr[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h1234_5678; req_valid[0] = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("abort_rsp_err", 32'(rsp_err[0]), 32'd0);
      chk("abort_rsp_rdata", rsp_rdata[0], 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_req(0, 1'b0, 32'h20, '0, 0, '0, lat, rd, er, a1);
      chk("ld20_after_abort", rd, 32'hCAFE_F00D);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
